system_cpu_cpu_mul_seq: RTL and testbench
=========================================

# system_cpu_cpu_mul_seq

Multi-cycle 32x32 multiply sequencer for the CPU's multiply path. It reuses one registered 16x16 unsigned multiplier cell over four issue slots and accumulates the partial products into a 64-bit product. Signed and unsigned operands are handled by a high-word correction step. It returns the low word (MUL) or the high word (MULXUU/MULXSU/MULXSS) over a valid/ready handshake. It sits beside the execute stage and serves one request at a time.

## Interface
Parameters:
- none; all widths fixed (32-bit operands, 16-bit cell, 64-bit accumulator).

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort; drops the in-flight operation
- req_valid  in  1  request offered
- req_ready  out  1  high only in IDLE
- req_op  in  2  0=MUL (low word), 1=MULXUU, 2=MULXSU (a signed, b unsigned), 3=MULXSS
- req_a  in  32  operand a
- req_b  in  32  operand b
- rsp_valid  out  1  result held until accepted
- rsp_ready  in  1  consumer accepts
- rsp_data  out  32  result word
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE0, ISSUE1, ISSUE2, ISSUE3, DRAIN, FIX, RESP.
- IDLE: req_ready=1. On req_valid, latch a, b and op, clear the accumulator, and go to ISSUE0.
- The cell registers its product one edge after its inputs are driven.
  - ISSUE0 drives aL*bL.
  - ISSUE1 drives aL*bH; the accumulator adds aL*bL.
  - ISSUE2 drives aH*bL; the accumulator adds (aL*bH)<<16.
  - ISSUE3 drives aH*bH; the accumulator adds (aH*bL)<<16.
  - DRAIN: the accumulator adds (aH*bH)<<32.
- All additions are modulo 2^64 and unsigned. The cell inputs are don't-care outside the ISSUE states.
- FIX: the high word is reduced, modulo 2^32:
  - subtract b if op∈{2,3} and a[31];
  - also subtract a if op==3 and b[31].
  - The low word is unchanged.
- RESP: rsp_valid=1. rsp_data is acc[31:0] for op 0, otherwise acc[63:32]. When rsp_ready is high, go to IDLE.
- flush in any state returns the block to IDLE on the next edge with rsp_valid=0. In IDLE it has no effect. flush takes priority over rsp_ready and over req_valid.
- reset_n low, at any time, forces IDLE immediately and clears the accumulator.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, busy=0.
- Handshake: a request is accepted on the edge where req_valid&&req_ready. The request fields must be stable only in that cycle.
- Latency: rsp_valid is high after the 7th rising edge counted from the accepting edge, with the accepting edge as edge 1.
  - Edges 1–6 walk ISSUE0..FIX.
  - The 7th edge enters RESP.
- rsp_data is stable and rsp_valid stays high until the rsp_ready edge.
- When rsp_ready is high in the first RESP cycle, the block returns to IDLE. The next request can then be accepted one edge later.
- Minimum throughput: 1 result per 8 cycles.
- req_ready is combinationally the IDLE state decode. It does not depend on rsp_ready, so there is no bypass.
- Mid-operation reset or flush: no partial result ever appears on rsp_valid.

## Structure
- Shared package (system_cpu_cpu_mul_pkg):
  - state enum;
  - op encoding constants MUL_OP_LO, MUL_OP_XUU, MUL_OP_XSU, MUL_OP_XSS;
  - width constants (32/16/64).
- One sub-module: system_cpu_cpu_mul16_cell.
  - 16x16 unsigned multiplier with a registered 32-bit product.
  - Inputs: clk, reset_n, dataa, datab, ena.
  - ena is high only in the ISSUE states.
- The top level holds the FSM, operand latches, the 64-bit accumulator with its shift mux, and the FIX subtractor.

## Test plan
- MUL: a=0x0001_0003, b=0x0002_0005 -> rsp_data=0x000B_000F.
- MULXUU: a=b=0xFFFF_FFFF -> rsp_data=0xFFFF_FFFE. Check that rsp_valid rises exactly 7 edges after acceptance.
- Signed high word:
  - MULXSS with a=0xFFFF_FFFF (-1), b=0x0000_0002 -> 0xFFFF_FFFF.
  - MULXSU with a=0x8000_0000, b=0xFFFF_FFFF -> 0x8000_0000.
- Backpressure: hold rsp_ready=0 for 5 cycles.
  - rsp_valid and rsp_data stay stable and req_ready stays 0.
  - After the accept edge, req_ready=1 on the next cycle.
  - A back-to-back request then completes correctly.
- flush in ISSUE2 -> IDLE on the next edge with no rsp_valid. The next request (MULXUU, 0x0001_0000 × 0x0001_0000) returns 0x0000_0001.
- Assert reset_n low in DRAIN -> outputs go to reset values asynchronously. After release, MUL 7×6 returns 42.

Source files
------------

// File: rtl/system_cpu_cpu_mul_pkg.sv
// Shared definitions for the sequential 32x32 multiplier.
// Holds the FSM state encoding, the operation codes carried on req_op
// and the fixed datapath widths.
package system_cpu_cpu_mul_pkg;

    localparam int MUL_W  = 32;   // operand / result word
    localparam int CELL_W = 16;   // multiplier cell input width
    localparam int ACC_W  = 64;   // full product accumulator

    localparam logic [1:0] MUL_OP_LO  = 2'd0;  // low word of product
    localparam logic [1:0] MUL_OP_XUU = 2'd1;  // high word, unsigned x unsigned
    localparam logic [1:0] MUL_OP_XSU = 2'd2;  // high word, signed a x unsigned b
    localparam logic [1:0] MUL_OP_XSS = 2'd3;  // high word, signed x signed

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
        ST_ISSUE1 = 3'd2,
        ST_ISSUE2 = 3'd3,
        ST_ISSUE3 = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_FIX    = 3'd6,
        ST_RESP   = 3'd7
    } mul_state_e;

endpackage

// File: rtl/system_cpu_cpu_mul16_cell.sv
// 16x16 unsigned multiplier with a registered 32-bit product.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   dataa, datab  16-bit unsigned operands
//   ena           capture dataa*datab on the next rising edge
//   result        registered product (holds when ena is low)
module system_cpu_cpu_mul16_cell
    import system_cpu_cpu_mul_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CELL_W-1:0]     dataa,
    input  logic [CELL_W-1:0]     datab,
    input  logic                  ena,
    output logic [2*CELL_W-1:0]   result
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result <= '0;
        end else if (ena) begin
            result <= dataa * datab;
        end
    end

endmodule

// File: rtl/system_cpu_cpu_mul_seq.sv
// Multi-cycle 32x32 multiply sequencer. One 16x16 cell is reused over four
// issue slots; partial products are summed into a 64-bit accumulator, the
// high word is then corrected for signed operands, and one word is returned.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   flush          synchronous abort of the in-flight operation
//   req_valid/req_ready, req_op, req_a, req_b   request channel
//   rsp_valid/rsp_ready, rsp_data                response channel
//   busy           high whenever the sequencer is not idle
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid is held with stable data until that edge, and ready never
// depends on the opposite channel's valid.
module system_cpu_cpu_mul_seq
    import system_cpu_cpu_mul_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [MUL_W-1:0]  req_a,
    input  logic [MUL_W-1:0]  req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [MUL_W-1:0]  rsp_data,
    output logic              busy
);

    mul_state_e          state, next_state;
    logic [MUL_W-1:0]    a_q, b_q;
    logic [1:0]          op_q;
    logic [ACC_W-1:0]    acc;
    logic [CELL_W-1:0]   cell_a, cell_b;
    logic [2*CELL_W-1:0] cell_p;
    logic                cell_ena;
    logic [ACC_W-1:0]    addend;
    logic [MUL_W-1:0]    hi_fix;
    logic                accept;

    assign accept = (state == ST_IDLE) && req_valid && !flush;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (req_valid) next_state = ST_ISSUE0;
            ST_ISSUE0: next_state = ST_ISSUE1;
            ST_ISSUE1: next_state = ST_ISSUE2;
            ST_ISSUE2: next_state = ST_ISSUE3;
            ST_ISSUE3: next_state = ST_DRAIN;
            ST_DRAIN:  next_state = ST_FIX;
            ST_FIX:    next_state = ST_RESP;
            ST_RESP:   if (rsp_ready) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
        if (flush) next_state = ST_IDLE;
    end

    // ---------------- multiplier cell ----------------
    // Each slot drives one 16x16 partial product; the cell result lands one
    // edge later, so the accumulator consumes it in the following state.
    always_comb begin
        cell_a   = '0;
        cell_b   = '0;
        cell_ena = 1'b1;
        case (state)
            ST_ISSUE0: begin cell_a = a_q[15:0];  cell_b = b_q[15:0];  end
            ST_ISSUE1: begin cell_a = a_q[15:0];  cell_b = b_q[31:16]; end
            ST_ISSUE2: begin cell_a = a_q[31:16]; cell_b = b_q[15:0];  end
            ST_ISSUE3: begin cell_a = a_q[31:16]; cell_b = b_q[31:16]; end
            default:   cell_ena = 1'b0;
        endcase
    end

    system_cpu_cpu_mul16_cell u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .dataa   (cell_a),
        .datab   (cell_b),
        .ena     (cell_ena),
        .result  (cell_p)
    );

    // Shift mux aligning the previous slot's partial product.
    always_comb begin
        addend = '0;
        case (state)
            ST_ISSUE1: addend = {32'd0, cell_p};
            ST_ISSUE2,
            ST_ISSUE3: addend = {16'd0, cell_p, 16'd0};
            ST_DRAIN:  addend = {cell_p, 32'd0};
            default:   addend = '0;
        endcase
    end

    // Two's-complement correction of the unsigned high word:
    // a negative a contributes -b*2^32, a negative b contributes -a*2^32.
    always_comb begin
        hi_fix = acc[63:32];
        if ((op_q == MUL_OP_XSU || op_q == MUL_OP_XSS) && a_q[31])
            hi_fix = hi_fix - b_q;
        if (op_q == MUL_OP_XSS && b_q[31])
            hi_fix = hi_fix - a_q;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= MUL_OP_LO;
            acc  <= '0;
        end else if (accept) begin
            a_q  <= req_a;
            b_q  <= req_b;
            op_q <= req_op;
            acc  <= '0;
        end else if (state == ST_FIX) begin
            acc[63:32] <= hi_fix;
        end else begin
            acc <= acc + addend;
        end
    end

    // ---------------- outputs ----------------
    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_data  = (state != ST_RESP) ? '0 :
                       (op_q == MUL_OP_LO) ? acc[31:0] : acc[63:32];

endmodule

// File: tb/tb_system_cpu_cpu_mul_seq.sv
module tb_system_cpu_cpu_mul_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        busy;

    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    system_cpu_cpu_mul_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                chk("rsp_data", rsp_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Returns just after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit push);
        wait_idle();
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    task automatic wait_rsp();
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) chk("rsp_timeout", 32'd1, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;

        // MUL low word
        issue(2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b1);
        wait_rsp();

        // MULXUU with latency measurement (accepting edge is edge 1)
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        cnt = 1;
        while (!rsp_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("latency_edges", cnt, 32'd7);

        // signed high words
        issue(2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1);
        wait_rsp();
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        wait_rsp();

        // backpressure
        wait_idle();
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        issue(2'd0, 32'h0000_1000, 32'h0000_1000, 32'h0100_0000, 1'b1);
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_data", rsp_data, 32'h0100_0000);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_accept_req_ready", {31'd0, req_ready}, 32'd1);
        chk("post_accept_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        // back-to-back request
        req_op = 2'd0; req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF; req_valid = 1'b1;
        exp_q.push_back(32'h0000_0001);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("b2b_accepted_busy", {31'd0, busy}, 32'd1);
        wait_rsp();

        // flush in ISSUE2
        issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_req_ready", {31'd0, req_ready}, 32'd1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("flush_no_rsp", cnt, 32'd0);
        issue(2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b1);
        wait_rsp();

        // async reset in DRAIN
        issue(2'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'd0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_rsp_data", rsp_data, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        issue(2'd0, 32'd7, 32'd6, 32'd42, 1'b1);
        wait_rsp();

        // drain scoreboard
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
